rpc2_ctrl_status_irq: RTL



---
 rtl/rpc2_ctrl_status_irq_pkg.sv | 25 ++
 rtl/rpc2_ctrl_status_irq_if.sv | 24 ++
 rtl/rpc2_ctrl_status_irq_edge_det.sv | 24 ++
 rtl/rpc2_ctrl_status_irq.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/rpc2_ctrl_status_irq_pkg.sv
// Shared constants for the register-domain status/interrupt block:
// register offsets, ISR bit layout and default widths.
package rpc2_ctrl_status_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W     = 4;
    localparam int CNT_W_DEF  = 8;
    localparam int ISR_W      = 9;

    localparam logic [ADDR_W-1:0] STATUS_OFF = 4'h0;
    localparam logic [ADDR_W-1:0] ISR_OFF    = 4'h1;
    localparam logic [ADDR_W-1:0] IMR_OFF    = 4'h2;
    localparam logic [ADDR_W-1:0] ERRCNT_OFF = 4'h3;

    localparam int B_RD_DONE  = 0;
    localparam int B_WR_DONE  = 1;
    localparam int B_RD_STALL = 2;
    localparam int B_RD_RSTO  = 3;
    localparam int B_RD_SLV   = 4;
    localparam int B_RD_DEC   = 5;
    localparam int B_WR_RSTO  = 6;
    localparam int B_WR_SLV   = 7;
    localparam int B_WR_DEC   = 8;

endpackage

// File: rtl/rpc2_ctrl_status_irq_if.sv
// Single-cycle register access port between the AXI register slave
// (master side) and the status/interrupt block (slave side).
interface rpc2_ctrl_status_irq_if
    import rpc2_ctrl_status_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              reg_wr;
    logic              reg_rd;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_wdata;
    logic [DATA_W-1:0] reg_rdata;
    logic              reg_rvalid;

    modport master (
        output reg_wr, reg_rd, reg_addr, reg_wdata,
        input  reg_rdata, reg_rvalid
    );

    modport slave (
        input  reg_wr, reg_rd, reg_addr, reg_wdata,
        output reg_rdata, reg_rvalid
    );
endinterface

// File: rtl/rpc2_ctrl_status_irq_edge_det.sv
// Vector edge detector: rise/fall against a previous-value register
// that resets to 0, so a level already high at release reads as a rise.
module rpc2_ctrl_edge_det #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_in,
    output logic [W-1:0] o_rise,
    output logic [W-1:0] o_fall
);
    logic [W-1:0] r_prev;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_prev <= '0;
        end else begin
            r_prev <= i_in;
        end
    end

    assign o_rise = i_in & ~r_prev;
    assign o_fall = ~i_in & r_prev;
endmodule

// File: rtl/rpc2_ctrl_status_irq.sv
// Sticky W1C interrupt status, mask, registered irq and live activity reg.
// Optional error counters at offset 0x3 under RPC2_STATUS_ERRCNT_EN.
module rpc2_ctrl_status_irq
    import rpc2_ctrl_status_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_mem_rd_active,
    input  logic i_mem_wr_active,
    input  logic i_mem_rd_stall_status,
    input  logic i_mem_rd_rsto_status,
    input  logic i_mem_rd_slv_status,
    input  logic i_mem_rd_dec_status,
    input  logic i_mem_wr_rsto_status,
    input  logic i_mem_wr_slv_status,
    input  logic i_mem_wr_dec_status,
    rpc2_ctrl_status_irq_if.slave bus,
    output logic o_irq
);
    logic [ISR_W-1:0]  w_lvl;
    logic [ISR_W-1:0]  w_rise;
    logic [ISR_W-1:0]  w_fall;
    logic [ISR_W-1:0]  w_evt;
    logic [ISR_W-1:0]  w_w1c;
    logic [ISR_W-1:0]  w_isr_nxt;
    logic [ISR_W-1:0]  r_isr;
    logic [ISR_W-1:0]  r_imr;
    logic              r_irq;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;
    logic [DATA_W-1:0] w_rd_mux;
    logic [DATA_W-1:0] w_errcnt;
    logic              w_wr_isr;
    logic              w_wr_imr;
    logic              w_unused;

    // Input vector ordered to match the ISR bit layout.
    assign w_lvl = {
        i_mem_wr_dec_status,
        i_mem_wr_slv_status,
        i_mem_wr_rsto_status,
        i_mem_rd_dec_status,
        i_mem_rd_slv_status,
        i_mem_rd_rsto_status,
        i_mem_rd_stall_status,
        i_mem_wr_active,
        i_mem_rd_active
    };

    rpc2_ctrl_edge_det #(
        .W (ISR_W)
    ) u_edge (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_in    (w_lvl),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_evt = {
        w_rise[ISR_W-1:B_RD_STALL],
        w_fall[B_WR_DONE:B_RD_DONE]
    };

    assign w_wr_isr = bus.reg_wr && (bus.reg_addr == ISR_OFF);
    assign w_wr_imr = bus.reg_wr && (bus.reg_addr == IMR_OFF);
    assign w_w1c    = w_wr_isr ? bus.reg_wdata[ISR_W-1:0] : '0;

    // New events are OR'ed after the clear, so a coincident set wins.
    assign w_isr_nxt = (r_isr & ~w_w1c) | w_evt;

`ifdef RPC2_STATUS_ERRCNT_EN
    logic [CNT_W-1:0] r_rd_cnt;
    logic [CNT_W-1:0] r_wr_cnt;
    logic [CNT_W-1:0] w_rd_base;
    logic [CNT_W-1:0] w_wr_base;
    logic [CNT_W:0]   w_rd_sum;
    logic [CNT_W:0]   w_wr_sum;
    logic [2:0]       w_rd_inc;
    logic [1:0]       w_wr_inc;
    logic             w_wr_cnt;

    assign w_wr_cnt = bus.reg_wr && (bus.reg_addr == ERRCNT_OFF);
    assign w_rd_inc = 3'($countones(w_rise[B_RD_DEC:B_RD_STALL]));
    assign w_wr_inc = 2'($countones(w_rise[B_WR_DEC:B_WR_RSTO]));

    // A clear replaces the base, so the result equals this cycle's edges.
    assign w_rd_base = w_wr_cnt ? '0 : r_rd_cnt;
    assign w_wr_base = w_wr_cnt ? '0 : r_wr_cnt;
    assign w_rd_sum  = {1'b0, w_rd_base} + (CNT_W+1)'(w_rd_inc);
    assign w_wr_sum  = {1'b0, w_wr_base} + (CNT_W+1)'(w_wr_inc);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            r_rd_cnt <= w_rd_sum[CNT_W] ? '1 : w_rd_sum[CNT_W-1:0];
            r_wr_cnt <= w_wr_sum[CNT_W] ? '1 : w_wr_sum[CNT_W-1:0];
        end
    end

    assign w_errcnt = DATA_W'({r_wr_cnt, r_rd_cnt});
`else
    assign w_errcnt = '0;
`endif

    always_comb begin
        w_rd_mux = '0;
        case (bus.reg_addr)
            STATUS_OFF: w_rd_mux[1:0] = {i_mem_wr_active, i_mem_rd_active};
            ISR_OFF:    w_rd_mux[ISR_W-1:0] = r_isr;
            IMR_OFF:    w_rd_mux[ISR_W-1:0] = r_imr;
            ERRCNT_OFF: w_rd_mux = w_errcnt;
            default:    w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_isr    <= '0;
            r_imr    <= '0;
            r_irq    <= 1'b0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_isr    <= w_isr_nxt;
            if (w_wr_imr) begin
                r_imr <= bus.reg_wdata[ISR_W-1:0];
            end
            r_irq    <= |(r_isr & r_imr);
            r_rvalid <= bus.reg_rd;
            r_rdata  <= bus.reg_rd ? w_rd_mux : '0;
        end
    end

    assign bus.reg_rdata  = r_rdata;
    assign bus.reg_rvalid = r_rvalid;
    assign o_irq          = r_irq;

    assign w_unused = ^{
        bus.reg_wdata[DATA_W-1:ISR_W],
        w_rise[B_WR_DONE:B_RD_DONE],
        w_fall[ISR_W-1:B_RD_STALL]
    };
endmodule
